// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one async SRAM port between the CPU bus and a DMA port.
// Fixed SETUP/ACCESS/DONE/TURN strobe sequence; all outputs registered; ack in DONE.
module sram_bus_arbiter #(
   parameter int ADDR_W     = 21,
   parameter int DATA_W     = 8,
   parameter int ACCESS_CYC = 2,
   parameter int TURN_CYC   = 1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dout,
   input  logic [DATA_W-1:0] sram_din,
   output logic              sram_drive,
   output logic              sram_ncs,
   output logic              sram_noe,
   output logic              sram_nwe,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DONE,
      S_TURN
   } state_t;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DMA = 1'b1;
   localparam int   MAX_CYC = (ACCESS_CYC > TURN_CYC) ? ACCESS_CYC : TURN_CYC;
   localparam int   CNT_W   = $clog2(MAX_CYC + 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                gnt_q, gnt_d;
   logic                last_q, last_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0]   sram_dout_q, sram_dout_d;
   logic                sram_drive_q, sram_drive_d;
   logic                sram_ncs_q, sram_ncs_d;
   logic                sram_noe_q, sram_noe_d;
   logic                sram_nwe_q, sram_nwe_d;
   logic                cpu_ack_q, cpu_ack_d;
   logic                dma_ack_q, dma_ack_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
   logic                busy_q, busy_d;
   logic                pick_dma;
   logic                in_cycle;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      we_d        = we_q;
      sram_addr_d = sram_addr_q;
      sram_dout_d = sram_dout_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      // On a tie the port that did not win last time gets the bus.
      pick_dma    = dma_req && (!cpu_req || (last_q == GNT_CPU));

      case (state_q)
         S_IDLE: begin
            if (cpu_req || dma_req) begin
               gnt_d       = pick_dma;
               last_d      = pick_dma;
               we_d        = pick_dma ? dma_we : cpu_we;
               sram_addr_d = pick_dma ? dma_addr : cpu_addr;
               if (pick_dma ? dma_we : cpu_we) begin
                  sram_dout_d = pick_dma ? dma_wdata : cpu_wdata;
               end
               state_d     = S_SETUP;
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = CNT_W'(ACCESS_CYC - 1);
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               if (!we_q) begin
                  if (gnt_q == GNT_DMA) begin
                     dma_rdata_d = sram_din;
                  end else begin
                     cpu_rdata_d = sram_din;
                  end
               end
               if (gnt_q == GNT_DMA) begin
                  dma_ack_d = 1'b1;
               end else begin
                  cpu_ack_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (TURN_CYC == 0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_TURN;
               cnt_d   = CNT_W'(TURN_CYC - 1);
            end
         end
         S_TURN: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes are decoded from the next state so they leave a flop cleanly.
      in_cycle     = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_DONE);
      sram_ncs_d   = !in_cycle;
      sram_noe_d   = !((state_d == S_ACCESS) && !we_d);
      sram_nwe_d   = !((state_d == S_ACCESS) && we_d);
      sram_drive_d = in_cycle && we_d;
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         gnt_q        <= GNT_CPU;
         last_q       <= GNT_DMA;
         we_q         <= 1'b0;
         sram_addr_q  <= '0;
         sram_dout_q  <= '0;
         sram_drive_q <= 1'b0;
         sram_ncs_q   <= 1'b1;
         sram_noe_q   <= 1'b1;
         sram_nwe_q   <= 1'b1;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         last_q       <= last_d;
         we_q         <= we_d;
         sram_addr_q  <= sram_addr_d;
         sram_dout_q  <= sram_dout_d;
         sram_drive_q <= sram_drive_d;
         sram_ncs_q   <= sram_ncs_d;
         sram_noe_q   <= sram_noe_d;
         sram_nwe_q   <= sram_nwe_d;
         cpu_ack_q    <= cpu_ack_d;
         dma_ack_q    <= dma_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_rdata  = cpu_rdata_q;
   assign cpu_ack    = cpu_ack_q;
   assign dma_rdata  = dma_rdata_q;
   assign dma_ack    = dma_ack_q;
   assign sram_addr  = sram_addr_q;
   assign sram_dout  = sram_dout_q;
   assign sram_drive = sram_drive_q;
   assign sram_ncs   = sram_ncs_q;
   assign sram_noe   = sram_noe_q;
   assign sram_nwe   = sram_nwe_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench: default-parameter instance plus an ACCESS_CYC=1/TURN_CYC=0 instance,
// each with a small byte-wide SRAM model indexed by the low address byte.
module tb_sram_bus_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk_sys = ~clk_sys;

   // instance A: default timing
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [20:0] cpu_addr, dma_addr, sram_addr;
   logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, sram_dout, sram_din;
   logic        cpu_ack, dma_ack, sram_drive, sram_ncs, sram_noe, sram_nwe, busy;

   // instance B: ACCESS_CYC=1, TURN_CYC=0
   logic        b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
   logic [20:0] b_cpu_addr, b_dma_addr, b_sram_addr;
   logic [7:0]  b_cpu_wdata, b_dma_wdata, b_cpu_rdata, b_dma_rdata, b_sram_dout, b_sram_din;
   logic        b_cpu_ack, b_dma_ack, b_sram_drive, b_sram_ncs, b_sram_noe, b_sram_nwe, b_busy;

   sram_bus_arbiter dut_a (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
      .sram_drive(sram_drive), .sram_ncs(sram_ncs), .sram_noe(sram_noe), .sram_nwe(sram_nwe),
      .busy(busy)
   );

   sram_bus_arbiter #(.ACCESS_CYC(1), .TURN_CYC(0)) dut_b (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
      .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
      .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
      .sram_addr(b_sram_addr), .sram_dout(b_sram_dout), .sram_din(b_sram_din),
      .sram_drive(b_sram_drive), .sram_ncs(b_sram_ncs), .sram_noe(b_sram_noe), .sram_nwe(b_sram_nwe),
      .busy(b_busy)
   );

   // SRAM models: write while nCS/nWE low; read data follows the registered address
   logic [7:0] mem_a [0:255];
   logic [7:0] mem_b [0:255];

   always @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= 8'h00;
      end else if (!sram_ncs && !sram_nwe) begin
         mem_a[sram_addr[7:0]] <= sram_dout;
      end
      sram_din <= mem_a[sram_addr[7:0]];
   end

   always @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
      end else if (!b_sram_ncs && !b_sram_nwe) begin
         mem_b[b_sram_addr[7:0]] <= b_sram_dout;
      end
      b_sram_din <= mem_b[b_sram_addr[7:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Ticks until an ack on the selected instance; who=1 means DMA.
   task automatic wait_ack(input bit inst, output logic who, output int cyc);
      logic got;
      got = 1'b0;
      who = 1'b0;
      cyc = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         cyc++;
         if (inst == 1'b0 ? (cpu_ack | dma_ack) : (b_cpu_ack | b_dma_ack)) begin
            got = 1'b1;
            who = (inst == 1'b0) ? dma_ack : b_dma_ack;
         end
      end
      chk("ack_seen", {31'd0, got}, 32'd1);
   endtask

   // Strobe and ack invariants every cycle on both instances
   always @(negedge clk_sys) begin
      chk("a_oe_we_excl", {31'd0, sram_noe | sram_nwe}, 32'd1);
      chk("a_strobe_no_cs", {31'd0, (~sram_noe | ~sram_nwe) & sram_ncs}, 32'd0);
      chk("a_ack_excl", {31'd0, cpu_ack & dma_ack}, 32'd0);
      chk("b_oe_we_excl", {31'd0, b_sram_noe | b_sram_nwe}, 32'd1);
      chk("b_ack_excl", {31'd0, b_cpu_ack & b_dma_ack}, 32'd0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       who;
      int         cyc;
      // {ncs,noe,nwe,drive,cpu_ack,busy} for cycles 1..6 after the request is sampled
      logic [5:0] exp_w [6] = '{6'b011101, 6'b010101, 6'b010101, 6'b011111, 6'b111001, 6'b111000};
      logic [5:0] exp_r [6] = '{6'b011001, 6'b001001, 6'b001001, 6'b011011, 6'b111001, 6'b111000};
      logic       exp_who [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
      b_dma_req = 0; b_dma_we = 0; b_dma_addr = '0; b_dma_wdata = '0;
      tick(); tick();

      // reset state
      chk("rst_strobes", {28'd0, sram_ncs, sram_noe, sram_nwe, sram_drive}, 32'hE);
      chk("rst_addr", {11'd0, sram_addr}, 32'd0);
      chk("rst_dout", {24'd0, sram_dout}, 32'd0);
      chk("rst_acks_busy", {29'd0, cpu_ack, dma_ack, busy}, 32'd0);
      chk("rst_rdata", {16'd0, cpu_rdata, dma_rdata}, 32'd0);
      reset = 1'b0;
      tick();

      // 1: CPU write 0x1ABCD <= 0x5A
      cpu_we = 1; cpu_addr = 21'h1ABCD; cpu_wdata = 8'h5A; cpu_req = 1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("t1_c%0d", c + 1), {26'd0, sram_ncs, sram_noe, sram_nwe, sram_drive, cpu_ack, busy}, {26'd0, exp_w[c]});
         if (c == 0) begin
            chk("t1_addr", {11'd0, sram_addr}, 32'h1ABCD);
            chk("t1_dout", {24'd0, sram_dout}, 32'h5A);
         end
         if (c == 3) cpu_req = 0;
      end
      chk("t1_addr_hold", {11'd0, sram_addr}, 32'h1ABCD);

      // 2: CPU read back
      cpu_we = 0; cpu_req = 1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("t2_c%0d", c + 1), {26'd0, sram_ncs, sram_noe, sram_nwe, sram_drive, cpu_ack, busy}, {26'd0, exp_r[c]});
         if (c == 3) begin
            chk("t2_cpu_rdata", {24'd0, cpu_rdata}, 32'h5A);
            chk("t2_dma_rdata", {24'd0, dma_rdata}, 32'h00);
            cpu_req = 0;
         end
      end

      // 3: both requesting from reset release -> CPU, DMA, CPU, DMA, 6 cycles apart
      reset = 1'b1;
      cpu_we = 0; cpu_addr = 21'h00011; cpu_req = 1;
      dma_we = 0; dma_addr = 21'h00022; dma_req = 1;
      tick(); tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(1'b0, who, cyc);
         chk($sformatf("t3_who%0d", k), {31'd0, who}, {31'd0, exp_who[k]});
         chk($sformatf("t3_gap%0d", k), cyc, (k == 0) ? 32'd4 : 32'd6);
      end
      cpu_req = 0; dma_req = 0;
      tick(); tick();
      chk("t3_idle", {31'd0, busy}, 32'd0);

      // 4: DMA write held, CPU read of the same byte arrives mid-access
      dma_we = 1; dma_addr = 21'h00055; dma_wdata = 8'hA5; dma_req = 1;
      tick(); tick();
      chk("t4_dma_access", {31'd0, sram_nwe}, 32'd0);
      cpu_we = 0; cpu_addr = 21'h00055; cpu_req = 1;
      wait_ack(1'b0, who, cyc);
      chk("t4_who0", {31'd0, who}, 32'd1);
      chk("t4_gap0", cyc, 32'd2);
      wait_ack(1'b0, who, cyc);
      chk("t4_who1", {31'd0, who}, 32'd0);
      chk("t4_gap1", cyc, 32'd6);
      chk("t4_cpu_rdata", {24'd0, cpu_rdata}, 32'hA5);
      cpu_req = 0;
      wait_ack(1'b0, who, cyc);
      chk("t4_who2", {31'd0, who}, 32'd1);
      chk("t4_gap2", cyc, 32'd6);
      dma_req = 0;
      tick(); tick();

      // 5: reset during ACCESS of a write
      cpu_we = 1; cpu_addr = 21'h00077; cpu_wdata = 8'h33; cpu_req = 1;
      tick(); tick();
      chk("t5_in_access", {30'd0, sram_ncs, sram_nwe}, 32'd0);
      #2;
      reset = 1'b1; cpu_req = 0;
      #1;
      chk("t5_async_strobes", {28'd0, sram_ncs, sram_noe, sram_nwe, sram_drive}, 32'hE);
      chk("t5_async_busy_ack", {30'd0, busy, cpu_ack}, 32'd0);
      tick();
      chk("t5_rst_ack", {31'd0, cpu_ack}, 32'd0);
      reset = 1'b0;
      tick();
      chk("t5_post_idle", {29'd0, busy, sram_ncs, cpu_ack}, 32'b010);
      tick();
      chk("t5_post_idle2", {30'd0, busy, cpu_ack}, 32'd0);

      // 6: short timing instance
      b_dma_we = 1; b_dma_addr = 21'h00043; b_dma_wdata = 8'h3C; b_dma_req = 1;
      wait_ack(1'b1, who, cyc);
      chk("t6_dma_who", {31'd0, who}, 32'd1);
      chk("t6_dma_lat", cyc, 32'd3);
      b_dma_req = 0;
      tick();
      chk("t6_idle_no_turn", {31'd0, b_busy}, 32'd0);
      b_cpu_we = 1; b_cpu_addr = 21'h00042; b_cpu_wdata = 8'hC3; b_cpu_req = 1;
      wait_ack(1'b1, who, cyc);
      chk("t6_cpu_wr_lat", cyc, 32'd3);
      b_cpu_we = 0;
      wait_ack(1'b1, who, cyc);
      chk("t6_rd0_gap", cyc, 32'd4);
      chk("t6_rd0_data", {24'd0, b_cpu_rdata}, 32'hC3);
      b_cpu_addr = 21'h00043;
      wait_ack(1'b1, who, cyc);
      chk("t6_rd1_gap", cyc, 32'd4);
      chk("t6_rd1_data", {24'd0, b_cpu_rdata}, 32'h3C);
      chk("t6_dma_rdata", {24'd0, b_dma_rdata}, 32'h00);
      b_cpu_req = 0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
